// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: shares the single write port between
// single-cycle EXEC results and multi-cycle MEM load returns. MEM normally
// has priority; an aging counter forces an EXEC grant after STARVE_LIMIT
// consecutive EXEC losses. A scoreboard tracks registers with an
// outstanding load so decode can stall on RAW hazards.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        EXEC_VALID,
  input  logic [4:0]  EXEC_RD,
  input  logic [31:0] EXEC_DATA,
  output logic        EXEC_READY,
  input  logic        MEM_VALID,
  input  logic [4:0]  MEM_RD,
  input  logic [31:0] MEM_DATA,
  output logic        MEM_READY,
  input  logic        ISSUE_VALID,
  input  logic [4:0]  ISSUE_RD,
  output logic [31:0] BUSY_MASK,
  output logic        WRITE_ENABLE,
  output logic [4:0]  WRITE_ADDR,
  output logic [31:0] WRITE_DATA
);

  typedef enum logic [0:0] {
    MEM_PRIO   = 1'b0,
    EXEC_FORCE = 1'b1
  } state_e;

  localparam logic [2:0] LOSS_LIMIT = 3'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [2:0]  loss_cnt_q, loss_cnt_d;
  logic [2:0]  loss_inc_s;
  logic        exec_grant_s;
  logic        mem_grant_s;

  logic        write_enable_q, write_enable_d;
  logic [4:0]  write_addr_q, write_addr_d;
  logic [31:0] write_data_q, write_data_d;
  logic [31:0] busy_mask_q, busy_mask_d;

  // Saturating increment of the loss counter; never exceeds the limit.
  always_comb begin
    if (loss_cnt_q >= LOSS_LIMIT) begin
      loss_inc_s = LOSS_LIMIT;
    end else begin
      loss_inc_s = loss_cnt_q + 3'd1;
    end
  end

  // Arbitration FSM: grants depend only on the two VALIDs and current state.
  // Grants are suppressed while reset is asserted so in-flight handshakes drop.
  always_comb begin
    state_d      = state_q;
    loss_cnt_d   = loss_cnt_q;
    exec_grant_s = 1'b0;
    mem_grant_s  = 1'b0;
    if (!RSTN) begin
      state_d    = MEM_PRIO;
      loss_cnt_d = 3'd0;
    end else begin
      case (state_q)
        MEM_PRIO: begin
          if (MEM_VALID) begin
            mem_grant_s = 1'b1;
            if (EXEC_VALID) begin
              loss_cnt_d = loss_inc_s;
              if (loss_inc_s == LOSS_LIMIT) begin
                state_d = EXEC_FORCE;
              end else begin
                state_d = MEM_PRIO;
              end
            end else begin
              loss_cnt_d = loss_cnt_q;
            end
          end else if (EXEC_VALID) begin
            exec_grant_s = 1'b1;
            loss_cnt_d   = 3'd0;
          end else begin
            loss_cnt_d = loss_cnt_q;
          end
        end
        EXEC_FORCE: begin
          loss_cnt_d = 3'd0;
          state_d    = MEM_PRIO;
          if (EXEC_VALID) begin
            exec_grant_s = 1'b1;
          end else if (MEM_VALID) begin
            mem_grant_s = 1'b1;
          end else begin
            mem_grant_s = 1'b0;
          end
        end
        default: begin
          state_d    = MEM_PRIO;
          loss_cnt_d = 3'd0;
        end
      endcase
    end
  end

  // Write-port next state: a transfer drives the port in the following cycle;
  // x0 destinations update address/data but never strobe the write.
  always_comb begin
    write_enable_d = 1'b0;
    write_addr_d   = write_addr_q;
    write_data_d   = write_data_q;
    if (exec_grant_s) begin
      write_enable_d = (EXEC_RD != 5'd0);
      write_addr_d   = EXEC_RD;
      write_data_d   = EXEC_DATA;
    end else if (mem_grant_s) begin
      write_enable_d = (MEM_RD != 5'd0);
      write_addr_d   = MEM_RD;
      write_data_d   = MEM_DATA;
    end else begin
      write_enable_d = 1'b0;
    end
  end

  // Scoreboard next state: returning load clears, new issue sets (set wins).
  always_comb begin
    busy_mask_d = busy_mask_q;
    if (mem_grant_s) begin
      busy_mask_d[MEM_RD] = 1'b0;
    end else begin
      busy_mask_d = busy_mask_q;
    end
    if (ISSUE_VALID && (ISSUE_RD != 5'd0)) begin
      busy_mask_d[ISSUE_RD] = 1'b1;
    end else begin
      busy_mask_d[0] = 1'b0;
    end
    busy_mask_d[0] = 1'b0;
  end

  // State, counter, write port and scoreboard registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q        <= MEM_PRIO;
      loss_cnt_q     <= 3'd0;
      write_enable_q <= 1'b0;
      write_addr_q   <= 5'd0;
      write_data_q   <= 32'd0;
      busy_mask_q    <= 32'd0;
    end else begin
      state_q        <= state_d;
      loss_cnt_q     <= loss_cnt_d;
      write_enable_q <= write_enable_d;
      write_addr_q   <= write_addr_d;
      write_data_q   <= write_data_d;
      busy_mask_q    <= busy_mask_d;
    end
  end

  assign EXEC_READY   = exec_grant_s;
  assign MEM_READY    = mem_grant_s;
  assign BUSY_MASK    = busy_mask_q;
  assign WRITE_ENABLE = write_enable_q;
  assign WRITE_ADDR   = write_addr_q;
  assign WRITE_DATA   = write_data_q;

endmodule
